// File: rtl/decomp_pkg.sv
// Constants and state encoding shared by the refill feeder and the word-decompressing unpacker.
package decomp_pkg;

   localparam int WIDTH        = 128;
   localparam int WIDTH196     = 196;
   localparam int REFILL_LIMIT = WIDTH196 - WIDTH;
   localparam int CNT_W        = $clog2(WIDTH196 + 1);

   typedef logic [2:0] refill_state_e;

   localparam refill_state_e IDLE  = 3'd0;
   localparam refill_state_e PRIME = 3'd1;
   localparam refill_state_e RUN   = 3'd2;
   localparam refill_state_e DRAIN = 3'd3;
   localparam refill_state_e DONE  = 3'd4;

endpackage

// File: rtl/decomp_line_hold.sv
// One-entry compressed-line buffer; a pop and a push may coincide, replacing the entry in place.
module decomp_line_hold
   import decomp_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_en,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic         o_valid,
   output logic [W-1:0] o_data
);

   logic         r_v;
   logic [W-1:0] r_data;
   logic         w_push;

   assign o_ready = i_en & (~r_v | i_pop);
   assign w_push  = i_valid & o_ready;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_v    <= 1'b0;
         r_data <= '0;
      end else begin
         if (w_push) r_data <= i_data;
         r_v <= w_push | (r_v & ~i_pop);
      end
   end

   assign o_valid = r_v;
   assign o_data  = r_data;

endmodule

// File: rtl/decomp_stream_refill.sv
// Refill feeder for the unpacker: mirrors its bit window and reloads it when room opens up.
// Optional DECOMP_REFILL_STATS_EN adds saturating refill/stall counters.
module decomp_stream_refill #(
   parameter int WIDTH     = 128,
   parameter int WIDTH196  = 196,
   parameter int CONSUME_W = 7,
   parameter int BLK_W     = 16,
   parameter int MIN_BITS  = 24
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_start,
   input  logic [BLK_W-1:0]     i_block_bits,
   input  logic                 i_line_valid,
   input  logic [WIDTH-1:0]     i_line,
   output logic                 o_line_ready,
   input  logic [CONSUME_W-1:0] i_consume,
   output logic [WIDTH196-1:0]  o_data,
   output logic                 o_update,
   output logic                 o_decomp_en,
   output logic                 o_busy,
   output logic                 o_done
`ifdef DECOMP_REFILL_STATS_EN
   ,
   output logic [31:0]          o_refill_cnt,
   output logic [31:0]          o_stall_cnt
`endif
);

   import decomp_pkg::refill_state_e;
   import decomp_pkg::IDLE;
   import decomp_pkg::PRIME;
   import decomp_pkg::RUN;
   import decomp_pkg::DRAIN;
   import decomp_pkg::DONE;

   localparam int CW    = $clog2(WIDTH196 + 1);
   localparam int LIMIT = WIDTH196 - WIDTH;
   localparam int LW    = BLK_W + 1;
   localparam int LSH   = $clog2(WIDTH);

   refill_state_e       r_state;
   logic [WIDTH196-1:0] r_win;
   logic [CW-1:0]       r_cnt;
   logic [BLK_W-1:0]    r_used;
   logic [BLK_W-1:0]    r_block_bits;
   logic [LW-1:0]       r_lines_left;
   logic                r_zero_done;

   logic                w_active;
   logic                w_hold_v;
   logic [WIDTH-1:0]    w_hold_data;
   logic                w_line_ready;
   logic                w_last;
   logic                w_refill;
   logic                w_finish;
   logic [CW-1:0]       w_cons;
   logic [CW-1:0]       w_rem;
   logic [BLK_W-1:0]    w_used_next;
   logic [LW-1:0]       w_lines_init;
   logic [WIDTH196-1:0] w_shifted;
   logic [WIDTH196-1:0] w_merged;

   assign w_active = (r_state == PRIME) | (r_state == RUN) | (r_state == DRAIN);
   assign w_last   = (r_lines_left == '0) & ~w_hold_v;

   always_comb begin
      o_decomp_en = 1'b0;
      case (r_state)
         RUN:     o_decomp_en = (r_cnt >= CW'(MIN_BITS)) | (w_last & (r_cnt != '0));
         DRAIN:   o_decomp_en = (r_cnt != '0);
         default: o_decomp_en = 1'b0;
      endcase
   end

   // Over-consumption is a protocol error; the remainder saturates so the window never wraps.
   assign w_cons   = o_decomp_en ? CW'(i_consume) : '0;
   assign w_rem    = (w_cons > r_cnt) ? '0 : r_cnt - w_cons;
   assign w_refill = w_active & w_hold_v & (w_rem <= CW'(LIMIT));

   assign w_shifted = r_win >> w_cons;
   assign w_merged  = w_shifted | ({{LIMIT{1'b0}}, w_hold_data} << w_rem);

   assign w_used_next  = r_used + BLK_W'(w_cons);
   assign w_finish     = (w_used_next >= r_block_bits);
   assign w_lines_init = (LW'(i_block_bits) + LW'(WIDTH - 1)) >> LSH;

   assign o_data       = w_refill ? w_merged : '0;
   assign o_update     = w_refill;
   assign o_line_ready = w_line_ready;
   assign o_busy       = w_active;
   assign o_done       = (r_state == DONE) | r_zero_done;

   decomp_line_hold #(
      .W (WIDTH)
   ) u_hold (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_en    (w_active & (r_lines_left != '0)),
      .i_valid (i_line_valid),
      .o_ready (w_line_ready),
      .i_data  (i_line),
      .i_pop   (w_refill),
      .o_valid (w_hold_v),
      .o_data  (w_hold_data)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state      <= IDLE;
         r_win        <= '0;
         r_cnt        <= '0;
         r_used       <= '0;
         r_block_bits <= '0;
         r_lines_left <= '0;
         r_zero_done  <= 1'b0;
      end else begin
         r_zero_done <= 1'b0;
         r_used      <= w_used_next;
         if (w_line_ready & i_line_valid) r_lines_left <= r_lines_left - LW'(1);
         if (w_active) begin
            r_win <= w_refill ? w_merged : w_shifted;
            r_cnt <= w_rem + (w_refill ? CW'(WIDTH) : '0);
         end
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  if (i_block_bits == '0) begin
                     r_zero_done <= 1'b1;
                  end else begin
                     r_state      <= PRIME;
                     r_block_bits <= i_block_bits;
                     r_lines_left <= w_lines_init;
                     r_used       <= '0;
                  end
               end
            end
            PRIME: if (w_refill) r_state <= RUN;
            RUN:   if (w_last) r_state <= DRAIN;
            DRAIN: if (w_finish) r_state <= DONE;
            DONE: begin
               // Padding past the block length is dropped here.
               r_state <= IDLE;
               r_win   <= '0;
               r_cnt   <= '0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   a_cons_le_cnt: assert property (@(posedge i_clk) disable iff (!i_reset) (w_cons <= r_cnt));

`ifdef DECOMP_REFILL_STATS_EN
   logic [31:0] r_refill_cnt;
   logic [31:0] r_stall_cnt;
   logic        w_stall;

   assign w_stall = ((r_state == RUN) | (r_state == DRAIN)) & ~o_decomp_en;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_refill_cnt <= '0;
         r_stall_cnt  <= '0;
      end else if ((r_state == IDLE) & i_start) begin
         r_refill_cnt <= '0;
         r_stall_cnt  <= '0;
      end else begin
         if (w_refill & (r_refill_cnt != '1)) r_refill_cnt <= r_refill_cnt + 32'd1;
         if (w_stall & (r_stall_cnt != '1))   r_stall_cnt  <= r_stall_cnt + 32'd1;
      end
   end

   assign o_refill_cnt = r_refill_cnt;
   assign o_stall_cnt  = r_stall_cnt;
`endif

endmodule

// File: tb/tb_decomp_stream_refill.sv
// Scoreboard bench for decomp_stream_refill: a bit-stream reference model predicts each reload window.
module tb_decomp_stream_refill;

   localparam int W   = 128;
   localparam int WW  = 196;
   localparam int CSW = 7;
   localparam int BW  = 16;

   logic           i_clk = 1'b0;
   logic           i_reset = 1'b1;
   logic           i_start = 1'b0;
   logic [BW-1:0]  i_block_bits = '0;
   logic           i_line_valid = 1'b0;
   logic [W-1:0]   i_line = '0;
   logic           o_line_ready;
   logic [CSW-1:0] i_consume = '0;
   logic [WW-1:0]  o_data;
   logic           o_update;
   logic           o_decomp_en;
   logic           o_busy;
   logic           o_done;
`ifdef DECOMP_REFILL_STATS_EN
   logic [31:0]    o_refill_cnt;
   logic [31:0]    o_stall_cnt;
`endif

   decomp_stream_refill #(
      .WIDTH     (W),
      .WIDTH196  (WW),
      .CONSUME_W (CSW),
      .BLK_W     (BW),
      .MIN_BITS  (24)
   ) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_block_bits (i_block_bits),
      .i_line_valid (i_line_valid),
      .i_line       (i_line),
      .o_line_ready (o_line_ready),
      .i_consume    (i_consume),
      .o_data       (o_data),
      .o_update     (o_update),
      .o_decomp_en  (o_decomp_en),
      .o_busy       (o_busy),
      .o_done       (o_done)
`ifdef DECOMP_REFILL_STATS_EN
      ,
      .o_refill_cnt (o_refill_cnt),
      .o_stall_cnt  (o_stall_cnt)
`endif
   );

   always #5 i_clk = ~i_clk;

   int cyc = 0;
   always @(posedge i_clk) cyc <= cyc + 1;

   typedef struct { int c; logic [WW-1:0] d; } upd_t;
   typedef struct { int c; bit en; bit rdy; bit busy; bit chk_busy; bit done; } ctl_t;
   upd_t upd_q[$];
   ctl_t ctl_q[$];

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: the block is a flat bit stream; the window is stream[P .. loaded*128).
   int           m_phase = 0;   // 0 idle, 1 block active, 2 done cycle
   bit           m_zd = 1'b0;
   bit           m_drain = 1'b0;
   int           m_bits, m_nlines, m_loaded, m_acc, m_P;
   int           p_valid = 100;
   logic [W-1:0] m_lines [16];

   task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h", name, cyc, act, exp);
      end
   endtask

   function automatic bit mbit(input int i);
      logic [W-1:0] ln;
      ln = m_lines[i / W];
      return ln[i % W];
   endfunction

   task automatic tick(input bit start, input int bits);
      int cnt, cons, eff, rem;
      bit hold_v, en, refill, ready, valid, fin;
      logic [WW-1:0] exp;
      upd_t u;
      ctl_t k;
      cnt    = (m_phase == 1) ? m_loaded * W - m_P : 0;
      hold_v = (m_phase == 1) && (m_acc > m_loaded);
      en     = (m_phase == 1) && (m_loaded > 0) &&
               (cnt >= 24 || (m_loaded == m_nlines && cnt != 0));
      cons   = en ? int'($urandom_range((cnt < 127) ? cnt : 127, 0)) : int'($urandom_range(127, 0));
      eff    = en ? cons : 0;
      rem    = cnt - eff;
      refill = hold_v && (rem <= WW - W);
      ready  = (m_phase == 1) && (m_acc < m_nlines) && (!hold_v || refill);
      valid  = ($urandom_range(99, 0) < p_valid);

      i_start      = start;
      i_block_bits = BW'(bits);
      i_line_valid = valid;
      i_line       = (m_phase == 1 && m_acc < m_nlines) ? m_lines[m_acc] : {$urandom, $urandom, $urandom, $urandom};
      i_consume    = CSW'(cons);

      k.c = cyc; k.en = en; k.rdy = ready; k.busy = (m_phase == 1);
      k.chk_busy = (m_phase != 2); k.done = (m_phase == 2) || m_zd;
      ctl_q.push_back(k);
      if (refill) begin
         exp = '0;
         for (int b = 0; b < rem + W; b++) exp[b] = mbit(m_P + eff + b);
         u.c = cyc; u.d = exp;
         upd_q.push_back(u);
      end

      m_zd = (m_phase == 0) && start && (bits == 0);
      case (m_phase)
         0: if (start && bits != 0) begin
               m_bits = bits; m_nlines = (bits + W - 1) / W;
               for (int i = 0; i < m_nlines; i++) m_lines[i] = {$urandom, $urandom, $urandom, $urandom};
               m_loaded = 0; m_acc = 0; m_P = 0; m_drain = 1'b0; m_phase = 1;
            end
         1: begin
               fin     = m_drain && (m_P + eff >= m_bits);
               m_drain = (m_loaded == m_nlines);
               m_P     = m_P + eff;
               if (refill) m_loaded++;
               if (valid && ready) m_acc++;
               if (fin) m_phase = 2;
            end
         default: m_phase = 0;
      endcase
   endtask

   task automatic run_block(input int bits, input int pv);
      int budget;
      p_valid = pv;
      @(posedge i_clk); #1;
      tick(1'b1, bits);
      budget = 0;
      do begin
         @(posedge i_clk); #1;
         tick(1'b0, int'($urandom_range(65535, 0)));
         budget++;
      end while ((m_phase != 0 || m_zd) && budget < 3000);
      n_chk++;
      if (budget >= 3000) begin
         n_fail++;
         $display("FAIL block_timeout bits=%0d: used %0d cycles, required fewer than 3000", bits, budget);
      end
   endtask

   task automatic mid_reset();
      p_valid = 100;
      @(posedge i_clk); #1;
      tick(1'b1, 600);
      repeat (8) begin
         @(posedge i_clk); #1;
         tick(1'b0, 0);
      end
      @(posedge i_clk); #1;
      i_reset = 1'b0; i_start = 1'b0; i_line_valid = 1'b1; i_consume = '0;
      #1;
      check("rst_update", WW'(o_update), '0);
      check("rst_data", o_data, '0);
      check("rst_busy", WW'(o_busy), '0);
      check("rst_en", WW'(o_decomp_en), '0);
      check("rst_ready", WW'(o_line_ready), '0);
      check("rst_done", WW'(o_done), '0);
      m_phase = 0; m_zd = 1'b0;
      @(posedge i_clk); #1;
      i_reset = 1'b1;
   endtask

   initial begin : monitor
      ctl_t k;
      upd_t u;
      forever begin
         @(negedge i_clk);
         if (ctl_q.size() > 0) begin
            k = ctl_q.pop_front();
            check("cycle_align", WW'(cyc), WW'(k.c));
            check("decomp_en", WW'(o_decomp_en), WW'(k.en));
            check("line_ready", WW'(o_line_ready), WW'(k.rdy));
            check("done", WW'(o_done), WW'(k.done));
            if (k.chk_busy) check("busy", WW'(o_busy), WW'(k.busy));
         end
         if (o_update) begin
            if (upd_q.size() == 0) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_update at cycle %0d: got o_update=1, required 0", cyc);
            end else begin
               u = upd_q.pop_front();
               check("update_cycle", WW'(cyc), WW'(u.c));
               check("update_data", o_data, u.d);
            end
         end else begin
            check("data_zero", o_data, '0);
         end
      end
   end

   initial begin : stimulus
      #2 i_reset = 1'b0;
      #1;
      check("reset_update", WW'(o_update), '0);
      check("reset_data", o_data, '0);
      check("reset_busy", WW'(o_busy), '0);
      check("reset_en", WW'(o_decomp_en), '0);
      check("reset_ready", WW'(o_line_ready), '0);
      check("reset_done", WW'(o_done), '0);
      repeat (2) @(posedge i_clk);
      #1 i_reset = 1'b1;
      repeat (10) begin
         @(posedge i_clk); #1;
         tick(1'b0, 0);
      end
      run_block(256, 100);
      run_block(200, 100);
      run_block(0, 100);
      run_block(129, 70);
      run_block(1, 100);
      run_block(128, 50);
      mid_reset();
      run_block(384, 100);
      for (int i = 0; i < 20; i++) run_block(int'($urandom_range(2000, 1)), int'($urandom_range(100, 30)));
      repeat (2) begin
         @(posedge i_clk); #1;
         tick(1'b0, 0);
      end
      @(negedge i_clk);
      @(negedge i_clk);
      check("upd_queue_drained", WW'(upd_q.size()), '0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
